// File: rtl/rename_pkg.sv
// Rename-wide types and sizes shared by decode, rename and the preg free list.
package rename_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/preg_bitmap.sv
// One bit per physical register marking tags currently held in the free list.
// A clear and a query on the same tag in one cycle sees the clear first.
module preg_bitmap
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_en,
  input  preg_t clr_idx,
  input  logic  set_en,
  input  preg_t set_idx,
  input  preg_t query_idx,
  output logic  query_hit
);

  logic [NUM_PREGS-1:0] bits_q, bits_d;

  always_comb begin
    query_hit = bits_q[query_idx] && !(clr_en && (clr_idx == query_idx));
  end

  always_comb begin
    bits_d = bits_q;
    if (clr_en) bits_d[clr_idx] = 1'b0;
    if (set_en) bits_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        bits_q[i] <= (i >= NUM_AREGS);
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical register tags for rename.
// FREELIST_DOUBLE_FREE_CHECK_EN adds a membership bitmap and err_double_free.
module preg_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_ok,
  output preg_t               alloc_preg,
  input  logic                free_valid,
  input  preg_t               free_preg,
  output logic                stall_out,
  output logic [FL_CNT_W-1:0] free_count,
  output logic                err_overflow
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic                err_double_free
`endif
);

  localparam logic [FL_CNT_W-1:0] CNT_FULL = FL_CNT_W'(FL_DEPTH);
  localparam logic [FL_PTR_W-1:0] PTR_LAST = FL_PTR_W'(FL_DEPTH - 1);

  preg_t               entries_q [FL_DEPTH];
  preg_t               entries_d [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d;
  logic [FL_PTR_W-1:0] tail_q, tail_d;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic                err_ovf_q, err_ovf_d;

  logic empty, full, free_nz, free_dup, free_acc;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign alloc_ok   = alloc_req && !empty;
  assign alloc_preg = entries_q[head_q];
  assign stall_out  = empty;
  assign free_count = count_q;
  assign err_overflow = err_ovf_q;
  assign free_nz    = free_valid && (free_preg != '0);
  assign free_acc   = free_nz && !full && !free_dup;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic err_dbl_q, err_dbl_d;
  logic in_list;

  preg_bitmap u_bitmap (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (alloc_ok),
    .clr_idx   (alloc_preg),
    .set_en    (free_acc),
    .set_idx   (free_preg),
    .query_idx (free_preg),
    .query_hit (in_list)
  );

  assign free_dup        = in_list;
  assign err_double_free = err_dbl_q;

  always_comb begin
    err_dbl_d = err_dbl_q;
    if (free_nz && !full && in_list) err_dbl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_dbl_q <= 1'b0;
    else     err_dbl_q <= err_dbl_d;
  end
`else
  assign free_dup = 1'b0;
`endif

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_ovf_d = err_ovf_q;
    if (alloc_ok)
      head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
    if (free_acc) begin
      entries_d[tail_q] = free_preg;
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
    end
    if (free_nz && full) err_ovf_d = 1'b1;
    count_d = count_q + FL_CNT_W'(free_acc) - FL_CNT_W'(alloc_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entries_q[i] <= preg_t'(NUM_AREGS + i);
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= CNT_FULL;
      err_ovf_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list.
// Define FREELIST_DOUBLE_FREE_CHECK_EN to also cover the double-free bitmap.
module tb_preg_free_list;
  import rename_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                alloc_req;
  logic                alloc_ok;
  preg_t               alloc_preg;
  logic                free_valid;
  preg_t               free_preg;
  logic                stall_out;
  logic [FL_CNT_W-1:0] free_count;
  logic                err_overflow;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic                err_double_free;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ok     (alloc_ok),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .stall_out    (stall_out),
    .free_count   (free_count),
    .err_overflow (err_overflow)
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    ,
    .err_double_free (err_double_free)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_preg  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"},   int'(free_count),   32);
    chk({tag, "_head"},  int'(alloc_preg),   32);
    chk({tag, "_stall"}, int'(stall_out),    0);
    chk({tag, "_ovf"},   int'(err_overflow), 0);
  endtask

  initial begin
    int exp_q[5];
    exp_q = '{4, 5, 50, 51, 52};

    // 1: reset state
    do_reset();
    chk_reset("rst");
    chk("rst_ok_idle", int'(alloc_ok), 0);
    alloc_req = 1'b1;
    #1;
    chk("rst_ok_req", int'(alloc_ok), 1);

    // 2: drain all 32 tags in order
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      #1;
      chk($sformatf("drain_tag%0d", i), int'(alloc_preg), 32 + i);
      chk($sformatf("drain_ok%0d", i), int'(alloc_ok), 1);
      step();
    end
    chk("empty_cnt",   int'(free_count), 0);
    chk("empty_stall", int'(stall_out),  1);
    chk("empty_ok",    int'(alloc_ok),   0);

    // 3: free into empty list, no bypass
    free_valid = 1'b1;
    free_preg  = 6'd40;
    #1;
    chk("nobyp_ok", int'(alloc_ok), 0);
    step();
    free_valid = 1'b0;
    #1;
    chk("nobyp_cnt", int'(free_count), 1);
    chk("nobyp_tag", int'(alloc_preg), 40);
    chk("nobyp_ok2", int'(alloc_ok),   1);
    step();
    alloc_req = 1'b0;
    #1;
    chk("nobyp_cnt0", int'(free_count), 0);

    // 4: simultaneous alloc and free keep count steady, FIFO order kept
    for (int i = 1; i <= 5; i++) begin
      free_valid = 1'b1;
      free_preg  = preg_t'(i);
      step();
    end
    chk("sim_cnt5", int'(free_count), 5);
    for (int i = 0; i < 3; i++) begin
      alloc_req  = 1'b1;
      free_valid = 1'b1;
      free_preg  = preg_t'(50 + i);
      #1;
      chk($sformatf("sim_tag%0d", i), int'(alloc_preg), i + 1);
      step();
      chk($sformatf("sim_cnt%0d", i), int'(free_count), 5);
    end
    free_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alloc_req = 1'b1;
      #1;
      chk($sformatf("order_tag%0d", i), int'(alloc_preg), exp_q[i]);
      step();
    end
    alloc_req = 1'b0;
    #1;
    chk("order_cnt0", int'(free_count), 0);

    // 5: p0 never recycled; overflow is sticky; reset clears all
    free_valid = 1'b1;
    free_preg  = '0;
    step();
    free_valid = 1'b0;
    #1;
    chk("p0_cnt",   int'(free_count), 0);
    chk("p0_stall", int'(stall_out),  1);

    do_reset();
    chk_reset("rst2");
    free_valid = 1'b1;
    free_preg  = 6'd7;
    step();
    free_valid = 1'b0;
    #1;
    chk("ovf_set", int'(err_overflow), 1);
    chk("ovf_cnt", int'(free_count),   32);
    chk("ovf_head", int'(alloc_preg),  32);
    alloc_req = 1'b1;
    step();
    step();
    alloc_req = 1'b0;
    #1;
    chk("ovf_sticky", int'(err_overflow), 1);
    chk("ovf_cnt30",  int'(free_count),   30);

    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_preg  = 6'd9;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    chk_reset("midrst");

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    // 6: double-free detection
    alloc_req = 1'b1;
    step();
    step();
    alloc_req = 1'b0;
    #1;
    chk("dbl_cnt30", int'(free_count), 30);
    alloc_req  = 1'b1;
    free_valid = 1'b1;
    free_preg  = 6'd34;
    #1;
    chk("same_tag", int'(alloc_preg), 34);
    step();
    idle();
    #1;
    chk("same_cnt", int'(free_count),      30);
    chk("same_err", int'(err_double_free), 0);
    free_valid = 1'b1;
    free_preg  = 6'd32;
    step();
    step();
    free_valid = 1'b0;
    #1;
    chk("dbl_cnt",  int'(free_count),      31);
    chk("dbl_err",  int'(err_double_free), 1);
    chk("dbl_ovf",  int'(err_overflow),    0);
    step();
    chk("dbl_stky", int'(err_double_free), 1);
    do_reset();
    chk("dbl_rst",  int'(err_double_free), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
